// File: rtl/rs232_rx_if.sv
// Bundle of signals between the serial line, the RS-232 receiver and the fabric logic
// that consumes the received bytes. The receiver uses the master view; the line driver
// and byte consumer use the slave view.
`timescale 1ns/1ps

interface rs232_rx_if;
    logic       rx;
    logic [7:0] dataOut;
    logic       dataValid;
    logic       frameErr;
    logic       busy;

    modport master (
        input  rx,
        output dataOut,
        output dataValid,
        output frameErr,
        output busy
    );

    modport slave (
        output rx,
        input  dataOut,
        input  dataValid,
        input  frameErr,
        input  busy
    );
endinterface

// File: rtl/rs232_rx.sv
// 8N1 RS-232 receiver. The serial input is oversampled with clk after a two-flop
// synchroniser. A start bit is confirmed at its centre. Data and stop bits are then
// sampled at their centres. A good frame produces a one-cycle dataValid pulse with the
// byte on dataOut. A low stop bit produces a one-cycle frameErr pulse, and the receiver
// then waits for the line to return high before it looks for another start edge.
`timescale 1ns/1ps

module rs232_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input logic        clk,
    input logic        rst,
    rs232_rx_if.master bus
);

    localparam int CW       = $clog2(CLKS_PER_BIT);
    localparam int HALF_BIT = CLKS_PER_BIT / 2;

    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BRK   = 3'd4
    } stateT;

    stateT         state;
    logic [CW-1:0] counter;
    logic [2:0]    bitIdx;
    logic [7:0]    shift;
    logic          rxMeta;
    logic          rxSync;
    logic [7:0]    dataOutReg;
    logic          dataValidReg;
    logic          frameErrReg;
    logic          busyReg;

    assign bus.dataOut   = dataOutReg;
    assign bus.dataValid = dataValidReg;
    assign bus.frameErr  = frameErrReg;
    assign bus.busy      = busyReg;

    // Synchronise rx, then walk the frame; outputs are registered and busy tracks the next state
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            counter      <= '0;
            bitIdx       <= '0;
            shift        <= '0;
            rxMeta       <= 1'b1;
            rxSync       <= 1'b1;
            dataOutReg   <= '0;
            dataValidReg <= 1'b0;
            frameErrReg  <= 1'b0;
            busyReg      <= 1'b0;
        end else begin
            rxMeta       <= bus.rx;
            rxSync       <= rxMeta;
            dataValidReg <= 1'b0;
            frameErrReg  <= 1'b0;

            case (state)
                IDLE: begin
                    counter <= '0;
                    bitIdx  <= '0;
                    if (!rxSync) begin
                        state   <= START;
                        busyReg <= 1'b1;
                    end
                end

                START: begin
                    if (counter == HALF_LAST) begin
                        counter <= '0;
                        if (rxSync) begin
                            state   <= IDLE;
                            busyReg <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end

                DATA: begin
                    if (counter == BIT_LAST) begin
                        counter <= '0;
                        shift   <= {rxSync, shift[7:1]};
                        bitIdx  <= bitIdx + 3'd1;
                        if (bitIdx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end

                STOP: begin
                    if (counter == BIT_LAST) begin
                        counter <= '0;
                        if (rxSync) begin
                            dataOutReg   <= shift;
                            dataValidReg <= 1'b1;
                            state        <= IDLE;
                            busyReg      <= 1'b0;
                        end else begin
                            frameErrReg <= 1'b1;
                            state       <= BRK;
                        end
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end

                BRK: begin
                    counter <= '0;
                    if (rxSync) begin
                        state   <= IDLE;
                        busyReg <= 1'b0;
                    end
                end

                default: begin
                    state   <= IDLE;
                    counter <= '0;
                    bitIdx  <= '0;
                    busyReg <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rs232_rx.sv
// Self-checking bench for rs232_rx at 434 clocks per bit. A table of frames is applied in
// a loop and checked against hand-computed results. Hand-written sequences cover the
// following cases:
//   - reset values and exact frame latency
//   - start-bit glitch rejection
//   - back-to-back frames
//   - reset in the middle of a frame
`timescale 1ns/1ps

module tb_rs232_rx;

    localparam int CPB = 434;
    localparam int HALF = CPB / 2;
    localparam int EXP_LATENCY = 3 + HALF + 9 * CPB;

    typedef struct {
        logic [7:0] data;
        int         clks;
        bit         stopBit;
        int         lowHold;
        int         expValid;
        int         expErr;
        logic [7:0] expOut;
    } vecT;

    logic clk = 1'b0;
    logic rst = 1'b0;

    rs232_rx_if bus();

    rs232_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int checks = 0;
    int failures = 0;

    int         edgeCount = 0;
    int         logCount = 0;
    int         errCount = 0;
    int         bothCount = 0;
    int         busyCycles = 0;
    int         lastValidEdge = 0;
    logic [7:0] logByte [0:63];

    vecT vecs [5];

    // Free-running clock
    always #5 clk = ~clk;

    // Count rising edges so frame latency can be measured
    always @(posedge clk) begin
        edgeCount <= edgeCount + 1;
    end

    // Record pulses and busy time on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (bus.dataValid) begin
            logByte[logCount[5:0]] <= bus.dataOut;
            logCount               <= logCount + 1;
            lastValidEdge          <= edgeCount;
        end
        if (bus.frameErr) begin
            errCount <= errCount + 1;
        end
        if (bus.dataValid && bus.frameErr) begin
            bothCount <= bothCount + 1;
        end
        if (bus.busy) begin
            busyCycles <= busyCycles + 1;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    task automatic driveLevel(input logic v, input int n);
        bus.rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] data, input int clks, input bit stopBit,
                                 input int lowHold, input int idleAfter);
        driveLevel(1'b0, clks);
        for (int i = 0; i < 8; i++) begin
            driveLevel(data[i], clks);
        end
        if (stopBit) begin
            driveLevel(1'b1, clks + idleAfter);
        end else begin
            driveLevel(1'b0, clks + lowHold);
            driveLevel(1'b1, idleAfter);
        end
    endtask

    initial begin
        int vBase;
        int eBase;
        int bBase;
        int startEdge;
        int busyDelta;

        vecs[0] = '{data: 8'h81, clks: 443, stopBit: 1'b1, lowHold: 0,    expValid: 1, expErr: 0, expOut: 8'h81};
        vecs[1] = '{data: 8'h81, clks: 425, stopBit: 1'b1, lowHold: 0,    expValid: 1, expErr: 0, expOut: 8'h81};
        vecs[2] = '{data: 8'h3C, clks: 434, stopBit: 1'b0, lowHold: 2000, expValid: 0, expErr: 1, expOut: 8'h81};
        vecs[3] = '{data: 8'h55, clks: 434, stopBit: 1'b1, lowHold: 0,    expValid: 1, expErr: 0, expOut: 8'h55};
        vecs[4] = '{data: 8'h00, clks: 434, stopBit: 1'b1, lowHold: 0,    expValid: 1, expErr: 0, expOut: 8'h00};

        bus.rx = 1'b1;
        rst    = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("reset dataOut", int'(bus.dataOut), 0);
        checkOutput("reset dataValid", int'(bus.dataValid), 0);
        checkOutput("reset frameErr", int'(bus.frameErr), 0);
        checkOutput("reset busy", int'(bus.busy), 0);
        rst = 1'b1;
        driveLevel(1'b1, 20);

        $display("[TB] frame 0xA5 with latency measurement");
        vBase     = logCount;
        eBase     = errCount;
        bBase     = busyCycles;
        startEdge = edgeCount;
        applyStimulus(8'hA5, CPB, 1'b1, 0, 300);
        checkOutput("A5 valid count", logCount - vBase, 1);
        checkOutput("A5 frameErr count", errCount - eBase, 0);
        checkOutput("A5 dataOut", int'(bus.dataOut), 8'hA5);
        checkOutput("A5 latency", lastValidEdge - startEdge, EXP_LATENCY);
        busyDelta = busyCycles - bBase;
        checkOutput("A5 busy length in range", int'(busyDelta >= 4118 && busyDelta <= 4130), 1);

        $display("[TB] table of frames");
        for (int i = 0; i < 5; i++) begin
            vBase = logCount;
            eBase = errCount;
            applyStimulus(vecs[i].data, vecs[i].clks, vecs[i].stopBit, vecs[i].lowHold, 300);
            checkOutput($sformatf("vec%0d valid count", i), logCount - vBase, vecs[i].expValid);
            checkOutput($sformatf("vec%0d frameErr count", i), errCount - eBase, vecs[i].expErr);
            checkOutput($sformatf("vec%0d dataOut", i), int'(bus.dataOut), int'(vecs[i].expOut));
        end

        $display("[TB] start glitch rejection");
        vBase = logCount;
        eBase = errCount;
        driveLevel(1'b0, 50);
        checkOutput("glitch busy during start", int'(bus.busy), 1);
        driveLevel(1'b0, 50);
        driveLevel(1'b1, 600);
        checkOutput("glitch valid count", logCount - vBase, 0);
        checkOutput("glitch frameErr count", errCount - eBase, 0);
        checkOutput("glitch dataOut", int'(bus.dataOut), 8'h00);
        checkOutput("glitch busy after", int'(bus.busy), 0);

        $display("[TB] back-to-back frames");
        vBase = logCount;
        eBase = errCount;
        applyStimulus(8'h00, CPB, 1'b1, 0, 0);
        applyStimulus(8'hFF, CPB, 1'b1, 0, 300);
        checkOutput("b2b valid count", logCount - vBase, 2);
        checkOutput("b2b frameErr count", errCount - eBase, 0);
        checkOutput("b2b first byte", int'(logByte[vBase[5:0]]), 8'h00);
        checkOutput("b2b second byte", int'(logByte[6'(vBase + 1)]), 8'hFF);

        $display("[TB] reset during data bit 4");
        vBase = logCount;
        eBase = errCount;
        driveLevel(1'b0, CPB);
        driveLevel(1'b0, 4 * CPB);
        driveLevel(1'b1, HALF);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("midreset dataOut", int'(bus.dataOut), 0);
        checkOutput("midreset busy", int'(bus.busy), 0);
        checkOutput("midreset dataValid", int'(bus.dataValid), 0);
        rst = 1'b1;
        driveLevel(1'b1, 1000);
        checkOutput("midreset no pulse", (logCount - vBase) + (errCount - eBase), 0);
        applyStimulus(8'h12, CPB, 1'b1, 0, 300);
        checkOutput("after reset valid count", logCount - vBase, 1);
        checkOutput("after reset dataOut", int'(bus.dataOut), 8'h12);

        checkOutput("valid and frameErr together", bothCount, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
